// File: rtl/i2c_pkg.sv
// Shared I2C types and constants.
// Used by the condition detector and the slave responder FSM.
package i2c_pkg;

    localparam int I2C_ADDR_BITS = 7;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

    typedef logic [3:0] i2c_slave_state_t;

    localparam i2c_slave_state_t S_IDLE     = 4'd0;
    localparam i2c_slave_state_t S_ADDR     = 4'd1;
    localparam i2c_slave_state_t S_ADDR_ACK = 4'd2;
    localparam i2c_slave_state_t S_WR_DATA  = 4'd3;
    localparam i2c_slave_state_t S_WR_ACK   = 4'd4;
    localparam i2c_slave_state_t S_RD_WAIT  = 4'd5;
    localparam i2c_slave_state_t S_RD_DATA  = 4'd6;
    localparam i2c_slave_state_t S_RD_ACK   = 4'd7;
    localparam i2c_slave_state_t S_IGNORE   = 4'd8;

    function automatic logic addr_hit(
        input logic [I2C_ADDR_BITS:0]   bus_byte,
        input logic [I2C_ADDR_BITS-1:0] own
    );
        return bus_byte[I2C_ADDR_BITS:1] == own;
    endfunction

endpackage

// File: rtl/i2c_cond_det.sv
// Bus synchronizers, scl edge detection and START/STOP detection.
// All outputs derive from the synchronized copies only.
module i2c_cond_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;
    logic       sda_s;

    // Idle bus is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign sda_s_o    = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_rsp.sv
// I2C slave responder: single 7-bit address, byte write strobe,
// read byte handshake with clock stretching while data is pending.
module i2c_slave_rsp
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_BITS-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                       I2C_DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o
);

    localparam int DW = I2C_DATA_WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic sda_s, scl_rise, scl_fall, cond_start, cond_stop;

    i2c_cond_det u_cond (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (cond_start),
        .stop_o     (cond_stop)
    );

    i2c_slave_state_t state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [DW-1:0]    shreg_q, shreg_d;
    logic [DW-1:0]    rdbuf_q, rdbuf_d;
    logic [DW-1:0]    wrdata_q, wrdata_d;
    i2c_op_t          rw_q, rw_d;
    logic             have_q, have_d;
    logic             ack_q, ack_d;
    logic             stretch_q, stretch_d;
    logic             sda_q, sda_d;
    logic             scl_q, scl_d;
    logic             wrvalid_q, wrvalid_d;
    logic             rdreq_q, rdreq_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             busy_q, busy_d;
    logic [DW-1:0]    rx_byte;

    assign rx_byte = {shreg_q[DW-2:0], sda_s};

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        rdbuf_d   = rdbuf_q;
        wrdata_d  = wrdata_q;
        rw_d      = rw_q;
        have_d    = have_q;
        ack_d     = ack_q;
        stretch_d = stretch_q;
        sda_d     = sda_q;
        scl_d     = scl_q;
        rdreq_d   = rdreq_q;
        busy_d    = busy_q;
        wrvalid_d = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;

        if (rdreq_q && rd_valid_i) begin
            rdbuf_d = rd_data_i;
            have_d  = 1'b1;
            rdreq_d = 1'b0;
        end

        if (cond_start || cond_stop) begin
            // Bus conditions override everything, including a same-cycle read byte.
            state_d   = cond_start ? S_ADDR : S_IDLE;
            start_d   = cond_start;
            stop_d    = cond_stop;
            busy_d    = cond_start;
            bitcnt_d  = '0;
            sda_d     = 1'b1;
            scl_d     = 1'b1;
            ack_d     = 1'b0;
            stretch_d = 1'b0;
            rdreq_d   = 1'b0;
            have_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST) begin
                            bitcnt_d = '0;
                            rw_d     = i2c_op_t'(sda_s);
                            ack_d    = 1'b0;
                            state_d  = addr_hit(rx_byte[I2C_ADDR_BITS:0], SLAVE_ADDR)
                                     ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            sda_d = 1'b0;
                            ack_d = 1'b1;
                            if (rw_q == READ) begin
                                rdreq_d = 1'b1;
                                have_d  = 1'b0;
                                ack_d   = 1'b0;
                                state_d = S_RD_WAIT;
                            end
                        end else begin
                            sda_d    = 1'b1;
                            ack_d    = 1'b0;
                            bitcnt_d = '0;
                            state_d  = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST) begin
                            bitcnt_d  = '0;
                            wrdata_d  = rx_byte;
                            wrvalid_d = 1'b1;
                            ack_d     = 1'b0;
                            state_d   = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_d = ack_q;
                        ack_d = ~ack_q;
                        if (ack_q) begin
                            state_d = S_WR_DATA;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // While stretching, set sda one cycle before releasing scl.
                    if (!stretch_q) begin
                        if (scl_fall) begin
                            if (have_q) begin
                                sda_d    = rdbuf_q[DW-1];
                                shreg_d  = {rdbuf_q[DW-2:0], 1'b0};
                                have_d   = 1'b0;
                                bitcnt_d = '0;
                                state_d  = S_RD_DATA;
                            end else begin
                                sda_d     = 1'b1;
                                scl_d     = 1'b0;
                                stretch_d = 1'b1;
                                ack_d     = 1'b0;
                            end
                        end
                    end else if (ack_q) begin
                        scl_d     = 1'b1;
                        stretch_d = 1'b0;
                        ack_d     = 1'b0;
                        state_d   = S_RD_DATA;
                    end else if (have_q) begin
                        sda_d    = rdbuf_q[DW-1];
                        shreg_d  = {rdbuf_q[DW-2:0], 1'b0};
                        have_d   = 1'b0;
                        bitcnt_d = '0;
                        ack_d    = 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == LAST) begin
                            sda_d    = 1'b1;
                            bitcnt_d = '0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sda_d    = shreg_q[DW-1];
                            shreg_d  = {shreg_q[DW-2:0], 1'b0};
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            rdreq_d = 1'b1;
                            have_d  = 1'b0;
                            state_d = S_RD_WAIT;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            rdbuf_q   <= '0;
            wrdata_q  <= '0;
            rw_q      <= WRITE;
            have_q    <= 1'b0;
            ack_q     <= 1'b0;
            stretch_q <= 1'b0;
            sda_q     <= 1'b1;
            scl_q     <= 1'b1;
            wrvalid_q <= 1'b0;
            rdreq_q   <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            rdbuf_q   <= rdbuf_d;
            wrdata_q  <= wrdata_d;
            rw_q      <= rw_d;
            have_q    <= have_d;
            ack_q     <= ack_d;
            stretch_q <= stretch_d;
            sda_q     <= sda_d;
            scl_q     <= scl_d;
            wrvalid_q <= wrvalid_d;
            rdreq_q   <= rdreq_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            busy_q    <= busy_d;
        end
    end

    assign scl_o      = scl_q;
    assign sda_o      = sda_q;
    assign wr_data_o  = wrdata_q;
    assign wr_valid_o = wrvalid_q;
    assign rd_req_o   = rdreq_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rsp.sv
// Bench for i2c_slave_rsp: bit-level master on a wired-AND bus,
// delayed read responder and write/read byte scoreboards.
module tb_i2c_slave_rsp;
    import i2c_pkg::*;

    localparam int Q = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_o, sda_o, wr_valid, rd_req, start, stop, busy;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] wr_data;
    logic       scl_bus, sda_bus;

    assign scl_bus = m_scl & scl_o;
    assign sda_bus = m_sda & sda_o;

    i2c_slave_rsp dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .wr_data_o  (wr_data),
        .wr_valid_o (wr_valid),
        .rd_req_o   (rd_req),
        .rd_data_i  (rd_data),
        .rd_valid_i (rd_valid),
        .start_o    (start),
        .stop_o     (stop),
        .busy_o     (busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rsp_q[$];

    int   n_wr, n_start, n_stop, n_rdreq, n_stretch;
    logic rd_req_p = 1'b0;

    always @(negedge clk) begin
        if (wr_valid) begin
            n_wr++;
            if (exp_wr.size() == 0) chk("wr_unexpected", 0, 1);
            else chk("wr_data", {24'h0, wr_data}, {24'h0, exp_wr.pop_front()});
        end
        if (start) n_start++;
        if (stop) n_stop++;
        if (rd_req && !rd_req_p) n_rdreq++;
        if (!scl_o) n_stretch++;
        rd_req_p = rd_req;
    end

    // Read responder: answers each request 20 cycles late.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req) begin
                repeat (20) @(negedge clk);
                rd_data = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
                exp_rd.push_back(rd_data);
                rd_valid = 1'b1;
                @(negedge clk);
                rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic clr();
        n_wr = 0; n_start = 0; n_stop = 0; n_rdreq = 0; n_stretch = 0;
    endtask

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_hi();
        int t = 0;
        m_scl = 1'b1;
        @(negedge clk);
        while (scl_bus !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("scl_timeout", t, 0);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; q_wait();
        scl_hi(); q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; q_wait();
        scl_hi(); q_wait();
        b = sda_bus;
        m_scl = 1'b0; q_wait();
    endtask

    task automatic start_c();
        m_sda = 1'b1; q_wait();
        scl_hi(); q_wait();
        m_sda = 1'b0; q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic stop_c();
        m_sda = 1'b0; q_wait();
        scl_hi(); q_wait();
        m_sda = 1'b1; q_wait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(input string tag, input logic mack);
        logic [7:0] b;
        logic       x;
        for (int i = 7; i >= 0; i--) begin
            get_bit(x);
            b[i] = x;
        end
        put_bit(mack);
        if (exp_rd.size() == 0) chk({tag, "_none"}, 0, 1);
        else chk(tag, {24'h0, b}, {24'h0, exp_rd.pop_front()});
    endtask

    logic ack;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs",
            {scl_o, sda_o, wr_valid, rd_req, start, stop, busy, wr_data},
            {7'b1100000, 8'h00});
        chk("rst_state", dut.state_q, S_IDLE);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0x78
        clr();
        start_c();
        send_byte(8'h44, ack);
        chk("w_addr_ack", ack, 0);
        chk("w_busy", busy, 1);
        exp_wr.push_back(8'h78);
        send_byte(8'h78, ack);
        chk("w_data_ack", ack, 0);
        stop_c();
        q_wait();
        chk("w_nwr", n_wr, 1);
        chk("w_nstart", n_start, 1);
        chk("w_nstop", n_stop, 1);
        chk("w_busy_end", busy, 0);
        chk("w_nostretch", n_stretch, 0);

        // Wrong address
        clr();
        start_c();
        send_byte(8'h46, ack);
        chk("na_nack", ack, 1);
        send_byte(8'h44, ack);
        chk("na_ign_nack", ack, 1);
        chk("na_state", dut.state_q, S_IGNORE);
        stop_c();
        q_wait();
        chk("na_nwr", n_wr, 0);
        chk("na_nrdreq", n_rdreq, 0);
        chk("na_idle", dut.state_q, S_IDLE);

        // Read one byte with stretch
        clr();
        rsp_q.push_back(8'hA5);
        start_c();
        send_byte(8'h45, ack);
        chk("r1_addr_ack", ack, 0);
        recv_byte("r1_data", 1'b1);
        stop_c();
        q_wait();
        chk("r1_stretched", n_stretch != 0, 1);
        chk("r1_nrdreq", n_rdreq, 1);

        // Read two bytes
        clr();
        rsp_q.push_back(8'h11);
        rsp_q.push_back(8'h22);
        start_c();
        send_byte(8'h45, ack);
        chk("r2_addr_ack", ack, 0);
        recv_byte("r2_data0", 1'b0);
        recv_byte("r2_data1", 1'b1);
        stop_c();
        q_wait();
        chk("r2_nrdreq", n_rdreq, 2);
        chk("r2_idle", dut.state_q, S_IDLE);
        chk("r2_busy", busy, 0);

        // Partial write, repeated START, read
        clr();
        rsp_q.push_back(8'h3C);
        start_c();
        send_byte(8'h44, ack);
        chk("rs_waddr_ack", ack, 0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        start_c();
        send_byte(8'h45, ack);
        chk("rs_raddr_ack", ack, 0);
        recv_byte("rs_data", 1'b1);
        stop_c();
        q_wait();
        chk("rs_nwr", n_wr, 0);
        chk("rs_nstart", n_start, 2);

        // Reset during write ACK
        clr();
        start_c();
        send_byte(8'h44, ack);
        exp_wr.push_back(8'h96);
        for (int i = 7; i >= 0; i--) put_bit(8'h96 >> i);
        chk("ra_ack_drv", sda_o, 0);
        chk("ra_state", dut.state_q, S_WR_ACK);
        rst_n = 1'b0;
        #1;
        chk("ra_sda_rel", sda_o, 1);
        chk("ra_scl_rel", scl_o, 1);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
        chk("ra_state_idle", dut.state_q, S_IDLE);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        start_c();
        send_byte(8'h44, ack);
        chk("ra2_addr_ack", ack, 0);
        exp_wr.push_back(8'h5A);
        send_byte(8'h5A, ack);
        chk("ra2_data_ack", ack, 0);
        stop_c();
        q_wait();
        chk("ra_nwr", n_wr, 2);

        chk("wr_queue_left", exp_wr.size(), 0);
        chk("rd_queue_left", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
